// File: rtl/ex_mdu_stage_pkg.sv
`default_nettype none
// ex_pkg: shared encodings for the execute stage and its iterative mul/div unit.
// Revision: 1.0
package ex_pkg;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_RTYPE = 2'b10;
  localparam logic [1:0] ALUOP_ITYPE = 2'b11;

  localparam logic [2:0] F3_ADD  = 3'b000;
  localparam logic [2:0] F3_SLL  = 3'b001;
  localparam logic [2:0] F3_SLT  = 3'b010;
  localparam logic [2:0] F3_SLTU = 3'b011;
  localparam logic [2:0] F3_XOR  = 3'b100;
  localparam logic [2:0] F3_SR   = 3'b101;
  localparam logic [2:0] F3_OR   = 3'b110;
  localparam logic [2:0] F3_AND  = 3'b111;

  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;
  localparam logic [2:0] F3_DIV    = 3'b100;
  localparam logic [2:0] F3_DIVU   = 3'b101;
  localparam logic [2:0] F3_REM    = 3'b110;
  localparam logic [2:0] F3_REMU   = 3'b111;

  localparam logic [6:0] F7_MULDIV = 7'b0000001;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } mdu_state_e;

  // A writer forwards only when it writes a non-x0 register matching the source.
  function automatic logic fwd_hit(input logic we, input logic [4:0] rd, input logic [4:0] rs);
    return we && (rd != 5'd0) && (rd == rs);
  endfunction

endpackage
`default_nettype wire

// File: rtl/ex_mdu_stage_if.sv
`default_nettype none
// ex_mdu_stage_if: ID/EX inputs, MEM/WB forwarding inputs and EX/MEM outputs.
// Revision: 1.0
interface ex_mdu_stage_if #(
  parameter int XLEN = 32
);
  logic [31:0]     inst_i;
  logic [XLEN-1:0] RDData0_i;
  logic [XLEN-1:0] RDData1_i;
  logic [XLEN-1:0] SignExtended_i;
  logic [4:0]      RSaddr_i;
  logic [4:0]      RTaddr_i;
  logic [4:0]      RegDst_i;
  logic [1:0]      ALUOp_i;
  logic            ALUSrc_i;
  logic            RegWrite_i;
  logic            MemToReg_i;
  logic            MemRead_i;
  logic            MemWrite_i;
  logic            WBRegWrite_i;
  logic [4:0]      WBRd_i;
  logic [XLEN-1:0] WBData_i;
  logic [XLEN-1:0] ALUResult_o;
  logic [XLEN-1:0] MemWData_o;
  logic            Zero_o;
  logic [4:0]      RegDst_o;
  logic            RegWrite_o;
  logic            MemToReg_o;
  logic            MemRead_o;
  logic            MemWrite_o;
  logic            stall_o;

  modport slave (
    input  inst_i, RDData0_i, RDData1_i, SignExtended_i, RSaddr_i, RTaddr_i, RegDst_i,
           ALUOp_i, ALUSrc_i, RegWrite_i, MemToReg_i, MemRead_i, MemWrite_i,
           WBRegWrite_i, WBRd_i, WBData_i,
    output ALUResult_o, MemWData_o, Zero_o, RegDst_o, RegWrite_o, MemToReg_o,
           MemRead_o, MemWrite_o, stall_o
  );

  modport master (
    output inst_i, RDData0_i, RDData1_i, SignExtended_i, RSaddr_i, RTaddr_i, RegDst_i,
           ALUOp_i, ALUSrc_i, RegWrite_i, MemToReg_i, MemRead_i, MemWrite_i,
           WBRegWrite_i, WBRd_i, WBData_i,
    input  ALUResult_o, MemWData_o, Zero_o, RegDst_o, RegWrite_o, MemToReg_o,
           MemRead_o, MemWrite_o, stall_o
  );
endinterface
`default_nettype wire

// File: rtl/ex_mdu_stage_mdu_iter.sv
`default_nettype none
// mdu_iter: 32-step shift-add multiplier / restoring divider on operand magnitudes.
// Revision: 1.0
module mdu_iter
  import ex_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        start_i,
  input  logic [2:0]  funct3_i,
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  output logic        busy_o,
  output logic        done_o,
  output logic [31:0] result_o
);
  mdu_state_e  state_q, state_d;
  logic [4:0]  count_q, count_d;
  logic [31:0] hi_q, hi_d, lo_q, lo_d, md_q, md_d;
  logic [2:0]  f3_q, f3_d;
  logic        a_neg_q, a_neg_d, b_neg_q, b_neg_d;

  logic        a_neg, b_neg;
  logic [32:0] add_sum;
  logic [32:0] div_rs;
  logic [33:0] div_diff;
  logic [63:0] prod_fix;
  logic [31:0] quot_fix, rem_fix;
  logic        unused_diff;

  assign a_neg = a_i[31] && !(funct3_i inside {F3_MULHU, F3_DIVU, F3_REMU});
  assign b_neg = b_i[31] && (funct3_i inside {F3_MUL, F3_MULH, F3_DIV, F3_REM});

  assign add_sum     = {1'b0, hi_q} + {1'b0, md_q};
  assign div_rs      = {hi_q, lo_q[31]};
  assign div_diff    = {1'b0, div_rs} - {2'b00, md_q};
  assign unused_diff = div_diff[32];

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    md_d    = md_q;
    f3_d    = f3_q;
    a_neg_d = a_neg_q;
    b_neg_d = b_neg_q;
    case (state_q)
      IDLE: begin
        if (start_i) begin
          state_d = BUSY;
          count_d = 5'd31;
          hi_d    = '0;
          lo_d    = a_neg ? -a_i : a_i;
          md_d    = b_neg ? -b_i : b_i;
          f3_d    = funct3_i;
          a_neg_d = a_neg;
          b_neg_d = b_neg;
        end
      end
      BUSY: begin
        if (f3_q[2]) begin
          // Restoring step: keep the trial difference only when it did not borrow.
          hi_d = div_diff[33] ? div_rs[31:0] : div_diff[31:0];
          lo_d = {lo_q[30:0], ~div_diff[33]};
        end else if (lo_q[0]) begin
          {hi_d, lo_d} = {add_sum, lo_q[31:1]};
        end else begin
          {hi_d, lo_d} = {1'b0, hi_q, lo_q[31:1]};
        end
        if (count_q == 5'd0) begin
          state_d = DONE;
        end else begin
          count_d = count_q - 5'd1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      count_q <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      md_q    <= '0;
      f3_q    <= '0;
      a_neg_q <= 1'b0;
      b_neg_q <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      md_q    <= md_d;
      f3_q    <= f3_d;
      a_neg_q <= a_neg_d;
      b_neg_q <= b_neg_d;
    end
  end

  // Signed overflow needs no special case: negating 0x80000000 yields itself.
  assign prod_fix = (a_neg_q ^ b_neg_q) ? -{hi_q, lo_q} : {hi_q, lo_q};
  assign quot_fix = (md_q == '0) ? '1 : ((a_neg_q ^ b_neg_q) ? -lo_q : lo_q);
  assign rem_fix  = a_neg_q ? -hi_q : hi_q;

  always_comb begin
    result_o = '0;
    case (f3_q)
      F3_MUL:                         result_o = prod_fix[31:0];
      F3_MULH, F3_MULHSU, F3_MULHU:   result_o = prod_fix[63:32];
      F3_DIV, F3_DIVU:                result_o = quot_fix;
      default:                        result_o = rem_fix;
    endcase
  end

  assign busy_o = (state_q == BUSY);
  assign done_o = (state_q == DONE);
endmodule
`default_nettype wire

// File: rtl/ex_mdu_stage.sv
`default_nettype none
// ex_mdu_stage: RV32 execute stage with forwarding, single-cycle ALU and iterative
// RV32M unit, registering results into the EX/MEM boundary. Revision: 1.0
module ex_mdu_stage
  import ex_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic          clk_i,
  input  logic          start_i,
  ex_mdu_stage_if.slave bus
);
  logic [XLEN-1:0] op_a, fwd_b, op_b, alu_res, sra_res, mdu_res, ex_res;
  logic [4:0]      shamt;
  logic [2:0]      funct3;
  logic [6:0]      funct7;
  logic            is_mop, mdu_start, mdu_busy, mdu_done, unused_inst;

  logic [XLEN-1:0] ALUResult_q, ALUResult_d, MemWData_q, MemWData_d;
  logic [4:0]      RegDst_q, RegDst_d;
  logic            Zero_q, Zero_d, RegWrite_q, RegWrite_d, MemToReg_q, MemToReg_d;
  logic            MemRead_q, MemRead_d, MemWrite_q, MemWrite_d;

  assign funct3      = bus.inst_i[14:12];
  assign funct7      = bus.inst_i[31:25];
  assign unused_inst = ^{bus.inst_i[24:15], bus.inst_i[11:0]};

  always_comb begin
    op_a = bus.RDData0_i;
    if (fwd_hit(RegWrite_q, RegDst_q, bus.RSaddr_i))              op_a = ALUResult_q;
    else if (fwd_hit(bus.WBRegWrite_i, bus.WBRd_i, bus.RSaddr_i)) op_a = bus.WBData_i;
    fwd_b = bus.RDData1_i;
    if (fwd_hit(RegWrite_q, RegDst_q, bus.RTaddr_i))              fwd_b = ALUResult_q;
    else if (fwd_hit(bus.WBRegWrite_i, bus.WBRd_i, bus.RTaddr_i)) fwd_b = bus.WBData_i;
  end

  assign op_b    = bus.ALUSrc_i ? bus.SignExtended_i : fwd_b;
  assign shamt   = op_b[4:0];
  assign sra_res = $unsigned($signed(op_a) >>> shamt);

  always_comb begin
    alu_res = op_a + op_b;
    case (bus.ALUOp_i)
      ALUOP_ADD: alu_res = op_a + op_b;
      ALUOP_SUB: alu_res = op_a - op_b;
      default: begin
        case (funct3)
          F3_ADD:  alu_res = (bus.ALUOp_i == ALUOP_RTYPE && funct7[5]) ? op_a - op_b : op_a + op_b;
          F3_SLL:  alu_res = op_a << shamt;
          F3_SLT:  alu_res = {{(XLEN-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
          F3_SLTU: alu_res = {{(XLEN-1){1'b0}}, (op_a < op_b)};
          F3_XOR:  alu_res = op_a ^ op_b;
          F3_SR:   alu_res = funct7[5] ? sra_res : (op_a >> shamt);
          F3_OR:   alu_res = op_a | op_b;
          default: alu_res = op_a & op_b;
        endcase
      end
    endcase
  end

  assign is_mop    = (bus.ALUOp_i == ALUOP_RTYPE) && (funct7 == F7_MULDIV);
  assign mdu_start = is_mop && !mdu_busy && !mdu_done;
  // Held low during reset so upstream is released immediately on an abort.
  assign bus.stall_o = start_i && (mdu_start || mdu_busy);

  mdu_iter u_mdu_iter (
    .clk_i    (clk_i),
    .rst_ni   (start_i),
    .start_i  (mdu_start),
    .funct3_i (funct3),
    .a_i      (op_a),
    .b_i      (op_b),
    .busy_o   (mdu_busy),
    .done_o   (mdu_done),
    .result_o (mdu_res)
  );

  assign ex_res = mdu_done ? mdu_res : alu_res;

  always_comb begin
    ALUResult_d = ALUResult_q;
    MemWData_d  = MemWData_q;
    Zero_d      = Zero_q;
    RegDst_d    = '0;
    RegWrite_d  = 1'b0;
    MemToReg_d  = 1'b0;
    MemRead_d   = 1'b0;
    MemWrite_d  = 1'b0;
    if (mdu_done || !(mdu_start || mdu_busy)) begin
      ALUResult_d = ex_res;
      MemWData_d  = fwd_b;
      Zero_d      = (ex_res == '0);
      RegDst_d    = bus.RegDst_i;
      RegWrite_d  = bus.RegWrite_i;
      MemToReg_d  = bus.MemToReg_i;
      MemRead_d   = bus.MemRead_i;
      MemWrite_d  = bus.MemWrite_i;
    end
  end

  always_ff @(posedge clk_i or negedge start_i) begin
    if (!start_i) begin
      ALUResult_q <= '0;
      MemWData_q  <= '0;
      Zero_q      <= 1'b0;
      RegDst_q    <= '0;
      RegWrite_q  <= 1'b0;
      MemToReg_q  <= 1'b0;
      MemRead_q   <= 1'b0;
      MemWrite_q  <= 1'b0;
    end else begin
      ALUResult_q <= ALUResult_d;
      MemWData_q  <= MemWData_d;
      Zero_q      <= Zero_d;
      RegDst_q    <= RegDst_d;
      RegWrite_q  <= RegWrite_d;
      MemToReg_q  <= MemToReg_d;
      MemRead_q   <= MemRead_d;
      MemWrite_q  <= MemWrite_d;
    end
  end

  assign bus.ALUResult_o = ALUResult_q;
  assign bus.MemWData_o  = MemWData_q;
  assign bus.Zero_o      = Zero_q;
  assign bus.RegDst_o    = RegDst_q;
  assign bus.RegWrite_o  = RegWrite_q;
  assign bus.MemToReg_o  = MemToReg_q;
  assign bus.MemRead_o   = MemRead_q;
  assign bus.MemWrite_o  = MemWrite_q;
endmodule
`default_nettype wire

// File: tb/tb_ex_mdu_stage.sv
`default_nettype none
// tb_ex_mdu_stage: vector table plus scoreboard for ALU, forwarding and M-op timing.
// Revision: 1.0
module tb_ex_mdu_stage;
  import ex_pkg::*;

  typedef struct {
    logic [1:0]  op;
    logic [6:0]  f7;
    logic [2:0]  f3;
    logic        src;
    logic [4:0]  rs1, rs2, rd;
    logic [31:0] rf0, rf1, imm;
    logic        wbwe;
    logic [4:0]  wbrd;
    logic [31:0] wbd;
    logic [3:0]  ctl;   // {RegWrite, MemToReg, MemRead, MemWrite}
    logic [31:0] exp, expwd;
  } vec_t;

  typedef struct {
    logic [31:0] res;
    logic [31:0] wd;
    logic [4:0]  rd;
    logic [3:0]  ctl;
  } exp_t;

  logic clk_i = 1'b0;
  logic start_i;
  always #5 clk_i = ~clk_i;

  ex_mdu_stage_if bus ();
  ex_mdu_stage dut (.clk_i(clk_i), .start_i(start_i), .bus(bus));

  exp_t sbq[$];
  vec_t vt[20];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string nm, input logic [95:0] act, input logic [95:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  function automatic vec_t rr(input logic [1:0] op, input logic [6:0] f7, input logic [2:0] f3,
                              input logic [31:0] a, input logic [31:0] b, input logic [31:0] e);
    vec_t v;
    v = '{op, f7, f3, 1'b0, 5'd1, 5'd2, 5'd3, a, b, 32'd0, 1'b0, 5'd0, 32'd0, 4'b1000, e, b};
    return v;
  endfunction

  function automatic vec_t ii(input logic [1:0] op, input logic [6:0] f7, input logic [2:0] f3,
                              input logic [31:0] a, input logic [31:0] imm, input logic [31:0] e);
    vec_t v;
    v = '{op, f7, f3, 1'b1, 5'd1, 5'd2, 5'd3, a, 32'h55, imm, 1'b0, 5'd0, 32'd0, 4'b1000, e, 32'h55};
    return v;
  endfunction

  task automatic drv(input vec_t v);
    bus.inst_i         = {v.f7, v.rs2, v.rs1, v.f3, v.rd, 7'h33};
    bus.ALUOp_i        = v.op;
    bus.ALUSrc_i       = v.src;
    bus.RSaddr_i       = v.rs1;
    bus.RTaddr_i       = v.rs2;
    bus.RegDst_i       = v.rd;
    bus.RDData0_i      = v.rf0;
    bus.RDData1_i      = v.rf1;
    bus.SignExtended_i = v.imm;
    bus.WBRegWrite_i   = v.wbwe;
    bus.WBRd_i         = v.wbrd;
    bus.WBData_i       = v.wbd;
    {bus.RegWrite_i, bus.MemToReg_i, bus.MemRead_i, bus.MemWrite_i} = v.ctl;
  endtask

  task automatic pop_check(input string tag);
    exp_t e;
    if (sbq.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL %s scoreboard_empty actual=none expected=entry", tag);
    end else begin
      e = sbq.pop_front();
      chk({tag, "_res"}, 96'(bus.ALUResult_o), 96'(e.res));
      chk({tag, "_zero"}, 96'(bus.Zero_o), 96'(e.res == 32'd0));
      chk({tag, "_wdata"}, 96'(bus.MemWData_o), 96'(e.wd));
      chk({tag, "_rd_ctl"},
          96'({bus.RegDst_o, bus.RegWrite_o, bus.MemToReg_o, bus.MemRead_o, bus.MemWrite_o}),
          96'({e.rd, e.ctl}));
    end
  endtask

  task automatic run_mop(input string tag, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] e);
    vec_t v;
    int   n;
    v = rr(ALUOP_RTYPE, F7_MULDIV, f3, a, b, e);
    v.rs1 = 5'd6;
    v.rs2 = 5'd7;
    v.rd  = 5'd5;
    drv(v);
    sbq.push_back('{e, b, 5'd5, 4'b1000});
    #1;
    n = 0;
    while (bus.stall_o === 1'b1 && n < 40) begin
      n++;
      @(posedge clk_i);
      #1;
      if (n == 1) chk({tag, "_bubble"}, 96'({bus.RegWrite_o, bus.RegDst_o}), 96'd0);
    end
    chk({tag, "_stall_cycles"}, 96'(n), 96'd33);
    @(posedge clk_i);
    #1;
    pop_check(tag);
  endtask

  initial begin
    vec_t v;
    start_i = 1'b0;
    drv(rr(ALUOP_ADD, 7'h00, 3'd0, 32'd0, 32'd0, 32'd0));
    repeat (2) @(posedge clk_i);
    #1;
    chk("reset_outputs",
        96'({bus.ALUResult_o, bus.MemWData_o, bus.Zero_o, bus.RegDst_o, bus.RegWrite_o,
             bus.MemToReg_o, bus.MemRead_o, bus.MemWrite_o}), 96'd0);
    chk("reset_stall", 96'(bus.stall_o), 96'd0);
    #2;
    start_i = 1'b1;
    @(posedge clk_i);
    #1;

    vt[0]  = rr(ALUOP_RTYPE, 7'h00, F3_ADD,  32'd5, 32'd7, 32'd12);
    vt[1]  = rr(ALUOP_RTYPE, 7'h20, F3_ADD,  32'd5, 32'd7, 32'hFFFF_FFFE);
    vt[2]  = rr(ALUOP_RTYPE, 7'h00, F3_SLL,  32'd1, 32'h24, 32'd16);
    vt[3]  = rr(ALUOP_RTYPE, 7'h00, F3_SLT,  32'hFFFF_FFFF, 32'd1, 32'd1);
    vt[4]  = rr(ALUOP_RTYPE, 7'h00, F3_SLTU, 32'hFFFF_FFFF, 32'd1, 32'd0);
    vt[5]  = rr(ALUOP_RTYPE, 7'h00, F3_XOR,  32'hF0F0, 32'hFF00, 32'h0FF0);
    vt[6]  = rr(ALUOP_RTYPE, 7'h00, F3_SR,   32'h8000_0000, 32'd4, 32'h0800_0000);
    vt[7]  = rr(ALUOP_RTYPE, 7'h20, F3_SR,   32'h8000_0000, 32'd4, 32'hF800_0000);
    vt[8]  = rr(ALUOP_RTYPE, 7'h00, F3_OR,   32'hF0F0, 32'h0F00, 32'hFFF0);
    vt[9]  = rr(ALUOP_RTYPE, 7'h00, F3_AND,  32'hF0F0, 32'h0FF0, 32'h00F0);
    vt[10] = ii(ALUOP_ITYPE, 7'h20, F3_ADD,  32'd10, 32'd3, 32'd13);
    vt[11] = ii(ALUOP_ADD,   7'h00, 3'd0,    32'd100, 32'hFFFF_FFFF, 32'd99);
    vt[11].ctl = 4'b1110;
    vt[12] = rr(ALUOP_SUB,   7'h00, 3'd0,    32'd5, 32'd5, 32'd0);
    vt[12].ctl = 4'b0001;
    vt[13] = ii(ALUOP_ITYPE, 7'h20, F3_SR,   32'h8000_0000, 32'd4, 32'hF800_0000);
    vt[14] = ii(ALUOP_ITYPE, 7'h00, F3_ADD,  32'd0, 32'd5, 32'd5);
    vt[14].rs1 = 5'd9;
    vt[14].rd  = 5'd1;
    vt[15] = rr(ALUOP_RTYPE, 7'h00, F3_ADD,  32'd99, 32'd99, 32'd12);
    vt[15].wbwe = 1'b1;
    vt[15].wbrd = 5'd2;
    vt[15].wbd  = 32'd7;
    vt[15].expwd = 32'd7;
    vt[16] = ii(ALUOP_ITYPE, 7'h00, F3_ADD,  32'd0, 32'd9, 32'd9);
    vt[16].rs1 = 5'd9;
    vt[16].rd  = 5'd0;
    vt[17] = rr(ALUOP_RTYPE, 7'h00, F3_ADD,  32'd0, 32'd4, 32'd4);
    vt[17].rs1  = 5'd0;
    vt[17].wbwe = 1'b1;
    vt[17].wbrd = 5'd0;
    vt[17].wbd  = 32'd55;
    vt[18] = vt[14];
    vt[19] = rr(ALUOP_RTYPE, 7'h00, F3_ADD,  32'd0, 32'd1, 32'd6);
    vt[19].wbwe = 1'b1;
    vt[19].wbrd = 5'd1;
    vt[19].wbd  = 32'd50;

    for (int i = 0; i < 20; i++) begin
      drv(vt[i]);
      sbq.push_back('{vt[i].exp, vt[i].expwd, vt[i].rd, vt[i].ctl});
      @(posedge clk_i);
      #1;
      pop_check($sformatf("vec%0d", i));
    end

    run_mop("mul",     F3_MUL,    32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFE);
    run_mop("mulhu",   F3_MULHU,  32'hFFFF_FFFF, 32'd2, 32'h0000_0001);
    run_mop("mulh",    F3_MULH,   32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFF);
    run_mop("mulhsu",  F3_MULHSU, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFF);
    run_mop("div",     F3_DIV,    32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD);
    run_mop("rem",     F3_REM,    32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF);
    run_mop("divu_z",  F3_DIVU,   32'd10, 32'd0, 32'hFFFF_FFFF);
    run_mop("rem_z",   F3_REM,    32'd10, 32'd0, 32'd10);

    v = rr(ALUOP_RTYPE, F7_MULDIV, F3_MUL, 32'hFFFF_FFFF, 32'd2, 32'd0);
    v.rs1 = 5'd6;
    v.rs2 = 5'd7;
    v.rd  = 5'd5;
    drv(v);
    repeat (10) @(posedge clk_i);
    #3;
    start_i = 1'b0;
    #1;
    chk("abort_outputs",
        96'({bus.ALUResult_o, bus.MemWData_o, bus.Zero_o, bus.RegDst_o, bus.RegWrite_o,
             bus.MemToReg_o, bus.MemRead_o, bus.MemWrite_o}), 96'd0);
    chk("abort_stall", 96'(bus.stall_o), 96'd0);
    v.op = ALUOP_ADD;
    drv(v);
    #1;
    start_i = 1'b1;
    @(posedge clk_i);
    #1;

    run_mop("div_ovf", F3_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000);
    run_mop("rem_ovf", F3_REM, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0);

    drv(rr(ALUOP_ADD, 7'h00, 3'd0, 32'd0, 32'd0, 32'd0));
    @(posedge clk_i);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/ex_mdu_stage.md
# ex_mdu_stage

Execute stage of the RV32 pipeline, sitting between the ID/EX pipeline register and the MEM stage. Selects forwarded operands, performs the single-cycle ALU operation or an iterative 32-cycle RV32M multiply/divide, and registers the result and control bits into the EX/MEM boundary. Asserts `stall_o` to freeze PC, IF/ID and ID/EX while a multiply/divide is in flight.

## Interface
Parameters:
- `XLEN`, 32, datapath width; only 32 is supported.

Ports:
- `clk_i`  in  1  clock; all state updates on the rising edge.
- `start_i`  in  1  reset, asynchronous, active-low.
- `inst_i`  in  32  instruction from ID/EX; funct3 = [14:12], funct7 = [31:25].
- `RDData0_i`, `RDData1_i`  in  32  register file operands rs1 and rs2.
- `SignExtended_i`  in  32  immediate.
- `RSaddr_i`, `RTaddr_i`, `RegDst_i`  in  5  rs1, rs2 and rd addresses.
- `ALUOp_i`  in  2  00 add, 01 sub, 10 R-type decode, 11 I-type decode.
- `ALUSrc_i`, `RegWrite_i`, `MemToReg_i`, `MemRead_i`, `MemWrite_i`  in  1  control bits from ID/EX.
- `WBRegWrite_i`  in  1  MEM/WB write enable.
- `WBRd_i`  in  5  MEM/WB destination.
- `WBData_i`  in  32  MEM/WB writeback value.
- `ALUResult_o`  out  32  registered result.
- `MemWData_o`  out  32  registered forwarded rs2 value for stores.
- `Zero_o`  out  1  registered, result == 0.
- `RegDst_o`  out  5  registered rd.
- `RegWrite_o`, `MemToReg_o`, `MemRead_o`, `MemWrite_o`  out  1  registered control bits.
- `stall_o`  out  1  combinational hold request for upstream stages.

## Operation
- Forwarding is applied per source, with priority in this order:
  1. EX/MEM: if `RegWrite_o && RegDst_o!=0 && RegDst_o==rs`, use `ALUResult_o`.
  2. MEM/WB: if `WBRegWrite_i && WBRd_i!=0 && WBRd_i==rs`, use `WBData_i`.
  3. Otherwise, use the register file value.
- Operand B is `SignExtended_i` when `ALUSrc_i`=1, otherwise the forwarded rs2.
- Single-cycle ops: ADD, SUB, SLL, SLT, SLTU, XOR, SRL, SRA, OR, AND, selected by funct3 and funct7[5]. I-type never subtracts. Shift amount is B[4:0].
- An M-op is `ALUOp_i`=10 with funct7 = 0000001. It is handled by a state machine:
  - IDLE: when an M-op is present, assert `stall_o`, latch A, B, funct3 and the signs, set count=31, and go to BUSY. EX/MEM receives a bubble.
  - BUSY: one shift-add or restoring-divide step per cycle on magnitudes. `stall_o`=1 and EX/MEM receives a bubble. When count==0, go to DONE; otherwise decrement count.
  - DONE: `stall_o`=0. Apply the sign fix-up and special cases, and register the result with the held ID/EX control bits. Return to IDLE. DONE never retriggers on the same instruction.
- M-op results:
  - MUL returns the low 32 bits of the product.
  - MULH, MULHSU and MULHU return the high 32 bits with signed×signed, signed×unsigned and unsigned×unsigned operands respectively.
  - DIV/REM: quotient is truncated toward zero; the remainder takes the sign of the dividend.
  - Divide by zero: quotient = FFFFFFFF, remainder = dividend.
  - Signed overflow (80000000 / FFFFFFFF): quotient = 80000000, remainder = 0.
- Bubble: RegWrite, MemToReg, MemRead, MemWrite and RegDst are 0. ALUResult and MemWData keep their previous values.

## Timing
- Every output resets to 0 and the state machine resets to IDLE.
- Reset mid-operation aborts the M-op. No partial result is ever written.
- Single-cycle op: EX/MEM outputs are valid 1 cycle after the op appears at the inputs.
- M-op: `stall_o` is high for exactly 33 consecutive cycles (IDLE entry plus 32 BUSY cycles). The result appears in EX/MEM at the edge ending DONE, i.e. 34 edges after the op appears.
- Inputs are sampled only in IDLE and DONE. Upstream must hold ID/EX stable while `stall_o`=1.
- `stall_o` depends only on state and the current decode. It has no path from the `WB*` inputs.

## Structure
- Package `ex_pkg` holds:
  - ALUOp encodings.
  - funct3 codes for the ALU and M-ops.
  - The funct7 M-op code.
  - The state enum {IDLE, BUSY, DONE}.
- One submodule, `mdu_iter`. It contains the iteration registers (accumulator, multiplicand/divisor, count) and the shift-add/restoring-divide datapath, including sign handling. It exposes start, busy and done handshake signals plus the result.
- The forwarding muxes, ALU and EX/MEM register stay in `ex_mdu_stage`.

## Test plan
- ADD x3=x1+x2 with rs1 forwarded from EX/MEM value 5 and rs2 forwarded from MEM/WB value 7 → `ALUResult_o`=12 after 1 cycle.
- rd=x0 writeback in EX/MEM matching rs1=0 → no forwarding; operand taken from the register file value 0.
- MUL 0xFFFFFFFF×2 → `stall_o` high for 33 cycles, then `ALUResult_o`=0xFFFFFFFE. MULHU on the same operands → 0x00000001.
- DIV −7/2 → result −3. REM −7/2 → result −1. DIVU 10/0 → 0xFFFFFFFF. REM 10/0 → 10.
- DIV 0x80000000/0xFFFFFFFF → 0x80000000. REM on the same operands → 0.
- `start_i` pulsed low during BUSY cycle 10 → all outputs 0 and `stall_o`=0 immediately. The next M-op completes normally with a full 33-cycle stall.
